// File: rtl/quad_step_decoder.sv
// Quadrature encoder front end: synchronises and deglitches A/B/index pins,
// decodes Gray phase transitions into one-cycle up/down/load commands and
// flags illegal double-bit phase jumps until cleared.
module quad_step_decoder #(
    parameter int unsigned FILT_LEN = 4,
    parameter int unsigned CNT_W    = 5,
    parameter int unsigned HOME_VAL = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enc_a,
    input  logic             enc_b,
    input  logic             enc_idx,
    input  logic             en,
    input  logic             clr_err,
    output logic             up,
    output logic             down,
    output logic             load,
    output logic [CNT_W-1:0] load_val,
    output logic             dir,
    output logic             err
);

    localparam int unsigned FCW = $clog2(FILT_LEN + 1);
    localparam int unsigned ICW = $clog2(FILT_LEN + 2);

    typedef enum logic [1:0] {StInit, StTrack, StFault} state_e;

    // Pin vector order: [2] index, [1] A, [0] B, so [1:0] is the {A,B} phase.
    logic [2:0]     pins;
    logic [2:0]     sync1_q, sync2_q;
    logic [2:0]     filt_q, filt_d;
    logic [FCW-1:0] fcnt_q [3];
    logic [FCW-1:0] fcnt_d [3];
    logic [2:0]     cur_q, prev_q;
    logic [ICW-1:0] icnt_q, icnt_d;
    state_e         state_q, state_d;
    logic           up_q, up_d, down_q, down_d, load_q, load_d, dir_q, dir_d;
    logic           step_up, step_dn, illegal, idx_rise;

    assign pins = {enc_idx, enc_a, enc_b};

    // Next phase in the forward (count-up) Gray sequence.
    function automatic logic [1:0] fwd_phase(input logic [1:0] p);
        case (p)
            2'b00:   fwd_phase = 2'b01;
            2'b01:   fwd_phase = 2'b11;
            2'b11:   fwd_phase = 2'b10;
            default: fwd_phase = 2'b00;
        endcase
    endfunction

    // Two-flop synchroniser for every asynchronous pin.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= pins;
            sync2_q <= sync1_q;
        end
    end

    // Per-pin stability filter; INIT bypasses it so the phase snaps to the pins.
    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < 3; i++) begin
            fcnt_d[i] = '0;
            if (state_q == StInit) begin
                filt_d[i] = sync2_q[i];
            end else if (sync2_q[i] != filt_q[i]) begin
                if (32'(fcnt_q[i]) + 32'd1 == FILT_LEN) begin
                    filt_d[i] = sync2_q[i];
                end else begin
                    fcnt_d[i] = fcnt_q[i] + FCW'(1);
                end
            end
        end
    end

    // Filter state plus the cur/prev phase pipeline feeding the decoder.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            filt_q <= '0;
            for (int i = 0; i < 3; i++) begin
                fcnt_q[i] <= '0;
            end
            cur_q  <= '0;
            prev_q <= '0;
        end else begin
            filt_q <= filt_d;
            fcnt_q <= fcnt_d;
            cur_q  <= filt_q;
            prev_q <= cur_q;
        end
    end

    assign step_up  = (cur_q[1:0] == fwd_phase(prev_q[1:0]));
    assign step_dn  = (prev_q[1:0] == fwd_phase(cur_q[1:0]));
    assign illegal  = ((cur_q[1:0] ^ prev_q[1:0]) == 2'b11);
    assign idx_rise = cur_q[2] & ~prev_q[2];

    // FSM next state and registered one-cycle commands.
    always_comb begin
        state_d = state_q;
        icnt_d  = icnt_q;
        up_d    = 1'b0;
        down_d  = 1'b0;
        load_d  = 1'b0;
        dir_d   = dir_q;
        case (state_q)
            StInit: begin
                if (32'(icnt_q) == FILT_LEN + 32'd1) begin
                    state_d = StTrack;
                    icnt_d  = '0;
                end else begin
                    icnt_d = icnt_q + ICW'(1);
                end
            end
            StTrack: begin
                if (illegal) begin
                    state_d = StFault;
                end else begin
                    if (step_up) dir_d = 1'b1;
                    if (step_dn) dir_d = 1'b0;
                    // Index load wins over a coincident step.
                    load_d = en & idx_rise;
                    up_d   = en & step_up & ~load_d;
                    down_d = en & step_dn & ~load_d;
                end
            end
            StFault: begin
                if (clr_err) begin
                    state_d = StInit;
                    icnt_d  = '0;
                end
            end
            default: state_d = StInit;
        endcase
    end

    // FSM state register and output flops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StInit;
            icnt_q  <= '0;
            up_q    <= 1'b0;
            down_q  <= 1'b0;
            load_q  <= 1'b0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            icnt_q  <= icnt_d;
            up_q    <= up_d;
            down_q  <= down_d;
            load_q  <= load_d;
            dir_q   <= dir_d;
        end
    end

    assign up       = up_q;
    assign down     = down_q;
    assign load     = load_q;
    assign dir      = dir_q;
    assign err      = (state_q == StFault);
    assign load_val = CNT_W'(HOME_VAL);

endmodule
